// File: rtl/beep_note_seq.sv
// Melody sequencer: walks a note ROM, maps pitch codes to PWM reload/compare values and
// gates the PWM enable for each note's duration, leaving a short articulation gap at the end.
module beep_note_seq #(
    parameter int unsigned CLK_FREQ    = 50_000_000,
    parameter int unsigned BEAT_CYCLES = 6_250_000,
    parameter int unsigned GAP_CYCLES  = 500_000,
    parameter int unsigned ADDR_W      = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              stop,
    input  logic              loop,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [7:0]        rom_data,
    output logic              busy,
    output logic              done,
    output logic              cnt_en,
    output logic [31:0]       counter_arr,
    output logic [31:0]       counter_ccr
);

    typedef enum logic [1:0] {StIdle, StFetch, StDecode, StPlay} state_e;

    localparam logic [ADDR_W-1:0] AddrOne = {{(ADDR_W-1){1'b0}}, 1'b1};

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
    logic [31:0]       note_cnt_q, note_cnt_d;
    logic [31:0]       arr_q, arr_d;
    logic [31:0]       ccr_q, ccr_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              cnt_en_q, cnt_en_d;

    logic [2:0]  dur_code;
    logic [4:0]  pitch_code;
    logic        pitched;
    logic [31:0] tone_arr;

    function automatic logic [31:0] period_m1(input int unsigned freq);
        return CLK_FREQ / freq - 32'd1;
    endfunction

    // Each branch folds to a constant at elaboration, so no divider is built.
    function automatic logic [31:0] tone_period(input logic [4:0] p);
        case (p)
            5'd1:    return period_m1(262);
            5'd2:    return period_m1(294);
            5'd3:    return period_m1(330);
            5'd4:    return period_m1(349);
            5'd5:    return period_m1(392);
            5'd6:    return period_m1(440);
            5'd7:    return period_m1(494);
            5'd8:    return period_m1(523);
            5'd9:    return period_m1(587);
            5'd10:   return period_m1(659);
            5'd11:   return period_m1(698);
            5'd12:   return period_m1(784);
            5'd13:   return period_m1(880);
            5'd14:   return period_m1(988);
            5'd15:   return period_m1(1047);
            5'd16:   return period_m1(1175);
            5'd17:   return period_m1(1319);
            5'd18:   return period_m1(1397);
            5'd19:   return period_m1(1568);
            5'd20:   return period_m1(1760);
            5'd21:   return period_m1(1976);
            default: return 32'd0;
        endcase
    endfunction

    always_comb begin
        dur_code   = rom_data[7:5];
        pitch_code = rom_data[4:0];
        pitched    = (pitch_code != 5'd0) && (pitch_code <= 5'd21);
        tone_arr   = tone_period(pitch_code);

        state_d    = state_q;
        rom_addr_d = rom_addr_q;
        note_cnt_d = note_cnt_q;
        arr_d      = arr_q;
        ccr_d      = ccr_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        cnt_en_d   = cnt_en_q;

        if (stop) begin
            state_d    = StIdle;
            rom_addr_d = '0;
            arr_d      = '0;
            ccr_d      = '0;
            busy_d     = 1'b0;
            cnt_en_d   = 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        state_d    = StFetch;
                        rom_addr_d = '0;
                        busy_d     = 1'b1;
                    end
                end
                StFetch: state_d = StDecode;
                StDecode: begin
                    // A zero duration code marks the end of the song.
                    if (dur_code == 3'd0) begin
                        rom_addr_d = '0;
                        if (loop) begin
                            state_d = StFetch;
                        end else begin
                            state_d = StIdle;
                            busy_d  = 1'b0;
                            done_d  = 1'b1;
                        end
                    end else begin
                        state_d    = StPlay;
                        note_cnt_d = 32'(dur_code) * BEAT_CYCLES - 32'd1;
                        arr_d      = pitched ? tone_arr : 32'd0;
                        ccr_d      = pitched ? (tone_arr >> 1) : 32'd0;
                        cnt_en_d   = pitched;
                    end
                end
                StPlay: begin
                    if (note_cnt_q == 32'd0) begin
                        state_d    = StFetch;
                        rom_addr_d = rom_addr_q + AddrOne;
                        cnt_en_d   = 1'b0;
                    end else begin
                        note_cnt_d = note_cnt_q - 32'd1;
                        // Enable drops once only GAP_CYCLES play cycles remain.
                        cnt_en_d   = cnt_en_q && (note_cnt_q > GAP_CYCLES);
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            rom_addr_q <= '0;
            note_cnt_q <= '0;
            arr_q      <= '0;
            ccr_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            cnt_en_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            rom_addr_q <= rom_addr_d;
            note_cnt_q <= note_cnt_d;
            arr_q      <= arr_d;
            ccr_q      <= ccr_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            cnt_en_q   <= cnt_en_d;
        end
    end

    assign rom_addr    = rom_addr_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign cnt_en      = cnt_en_q;
    assign counter_arr = arr_q;
    assign counter_ccr = ccr_q;

endmodule

// File: tb/tb_beep_note_seq.sv
// Bench for beep_note_seq: scenario tasks plus random songs, each cycle compared against a
// slot-level model of the song built from the ROM contents.
module tb_beep_note_seq;

    localparam int unsigned CLK_FREQ = 1_000_000;
    localparam int unsigned BEAT     = 100;
    localparam int unsigned GAP      = 10;
    localparam int unsigned AW       = 4;
    localparam int          ROM_N    = 16;

    logic          clk = 1'b0;
    logic          rst, start, stop, loop;
    logic [AW-1:0] rom_addr;
    logic [7:0]    rom_data;
    logic          busy, done, cnt_en;
    logic [31:0]   counter_arr, counter_ccr;

    logic [7:0] rom [ROM_N];

    int total = 0;
    int bad   = 0;

    int freq_tab [22] = '{0, 262, 294, 330, 349, 392, 440, 494, 523, 587, 659, 698, 784,
                          880, 988, 1047, 1175, 1319, 1397, 1568, 1760, 1976};

    typedef struct packed {
        logic          en;
        logic [31:0]   arr;
        logic [31:0]   ccr;
        logic          busy;
        logic          done;
        logic [AW-1:0] addr;
    } obs_t;

    obs_t exp_q[$];
    obs_t obs_q[$];

    always #5 clk = ~clk;

    always @(posedge clk) rom_data <= rom[rom_addr];

    beep_note_seq #(
        .CLK_FREQ   (CLK_FREQ),
        .BEAT_CYCLES(BEAT),
        .GAP_CYCLES (GAP),
        .ADDR_W     (AW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .stop       (stop),
        .loop       (loop),
        .rom_addr   (rom_addr),
        .rom_data   (rom_data),
        .busy       (busy),
        .done       (done),
        .cnt_en     (cnt_en),
        .counter_arr(counter_arr),
        .counter_ccr(counter_ccr)
    );

    function automatic obs_t sample();
        obs_t o;
        o.en   = cnt_en;
        o.arr  = counter_arr;
        o.ccr  = counter_ccr;
        o.busy = busy;
        o.done = done;
        o.addr = rom_addr;
        return o;
    endfunction

    // Expected outputs for cycles 1..n after start: each slot is fetch+decode, then the note.
    task automatic build_model(input bit lp, input int n);
        int          addr;
        logic [31:0] arr, ccr;
        logic [7:0]  w;
        int          d, p, len;
        bit          pitched;
        obs_t        o;
        addr = 0;
        arr  = 0;
        ccr  = 0;
        exp_q.delete();
        while (exp_q.size() < n) begin
            o.en = 1'b0; o.arr = arr; o.ccr = ccr; o.busy = 1'b1; o.done = 1'b0;
            o.addr = addr[AW-1:0];
            exp_q.push_back(o);
            exp_q.push_back(o);
            w = rom[addr];
            d = int'(w[7:5]);
            p = int'(w[4:0]);
            if (d == 0) begin
                addr = 0;
                if (!lp) begin
                    o.busy = 1'b0; o.done = 1'b1; o.addr = '0;
                    exp_q.push_back(o);
                    o.done = 1'b0;
                    while (exp_q.size() < n) exp_q.push_back(o);
                end
            end else begin
                pitched = (p >= 1) && (p <= 21);
                arr = pitched ? (CLK_FREQ / freq_tab[p] - 1) : 32'd0;
                ccr = arr >> 1;
                len = d * int'(BEAT);
                o.arr = arr; o.ccr = ccr;
                for (int k = 0; k < len; k++) begin
                    o.en = pitched && (k < len - int'(GAP));
                    exp_q.push_back(o);
                end
                addr = (addr + 1) % ROM_N;
            end
        end
        while (exp_q.size() > n) void'(exp_q.pop_back());
    endtask

    task automatic do_reset();
        rst = 1'b1; start = 1'b0; stop = 1'b0; loop = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // Starts the song and compares n cycles; optional extra start pulse at index restart_at.
    task automatic play(input bit lp, input int n, input int restart_at, input string tag);
        build_model(lp, n);
        obs_q.delete();
        @(posedge clk);
        #1 start = 1'b1; loop = lp;
        @(posedge clk);
        #1 start = 1'b0;
        for (int t = 0; t < n; t++) begin
            obs_t o;
            start = (t == restart_at);
            o = sample();
            obs_q.push_back(o);
            total++;
            if (o !== exp_q[t]) begin
                bad++;
                $display("FAIL %s cycle=%0d got en=%b arr=%0d ccr=%0d busy=%b done=%b addr=%0d want en=%b arr=%0d ccr=%0d busy=%b done=%b addr=%0d",
                         tag, t + 1, o.en, o.arr, o.ccr, o.busy, o.done, o.addr,
                         exp_q[t].en, exp_q[t].arr, exp_q[t].ccr, exp_q[t].busy,
                         exp_q[t].done, exp_q[t].addr);
            end
            @(posedge clk);
            #1;
        end
        start = 1'b0;
    endtask

    function automatic int count_en();
        int c = 0;
        foreach (obs_q[i]) if (obs_q[i].en) c++;
        return c;
    endfunction

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; stop = 1'b0; loop = 1'b0;
        #1;
        total++;
        if ({busy, done, cnt_en} !== 3'b000 || rom_addr !== '0 || counter_arr !== 32'd0 ||
            counter_ccr !== 32'd0) begin
            bad++;
            $display("FAIL reset_values got busy=%b done=%b en=%b addr=%0d arr=%0d ccr=%0d want all 0",
                     busy, done, cnt_en, rom_addr, counter_arr, counter_ccr);
        end
        do_reset();
    endtask

    task automatic test_single_note();
        foreach (rom[i]) rom[i] = 8'h00;
        rom[0] = 8'h46;
        do_reset();
        play(1'b0, 210, -1, "single_note");
        total++;
        if (obs_q[2].arr !== 32'd2271 || obs_q[2].ccr !== 32'd1135) begin
            bad++;
            $display("FAIL single_arr_ccr got arr=%0d ccr=%0d want arr=2271 ccr=1135",
                     obs_q[2].arr, obs_q[2].ccr);
        end
        total++;
        if (count_en() != 190) begin
            bad++;
            $display("FAIL single_en_len got %0d want 190", count_en());
        end
        total++;
        if (obs_q[204].done !== 1'b1 || obs_q[205].busy !== 1'b0) begin
            bad++;
            $display("FAIL single_done got done=%b busy_after=%b want done=1 busy_after=0",
                     obs_q[204].done, obs_q[205].busy);
        end
    endtask

    task automatic test_note_rest();
        foreach (rom[i]) rom[i] = 8'h00;
        rom[0] = 8'h2D;
        rom[1] = 8'h20;
        do_reset();
        play(1'b0, 212, -1, "note_rest");
        total++;
        if (obs_q[2].arr !== 32'd1135 || obs_q[2].ccr !== 32'd567 || count_en() != 90) begin
            bad++;
            $display("FAIL note_rest_note got arr=%0d ccr=%0d en_cycles=%0d want 1135 567 90",
                     obs_q[2].arr, obs_q[2].ccr, count_en());
        end
        total++;
        if (obs_q[104].arr !== 32'd0 || obs_q[104].en !== 1'b0 || obs_q[206].done !== 1'b1) begin
            bad++;
            $display("FAIL note_rest_rest got arr=%0d en=%b done=%b want 0 0 1",
                     obs_q[104].arr, obs_q[104].en, obs_q[206].done);
        end
    endtask

    task automatic test_loop();
        int ndone, nidle;
        foreach (rom[i]) rom[i] = 8'h00;
        rom[0] = 8'h46;
        do_reset();
        play(1'b1, 616, -1, "loop");
        ndone = 0; nidle = 0;
        foreach (obs_q[i]) begin
            if (obs_q[i].done) ndone++;
            if (!obs_q[i].busy) nidle++;
        end
        total++;
        if (ndone != 0 || nidle != 0) begin
            bad++;
            $display("FAIL loop_busy got done_pulses=%0d idle_cycles=%0d want 0 0", ndone, nidle);
        end
        total++;
        if (obs_q[206].en !== 1'b1 || obs_q[205].en !== 1'b0 || obs_q[410].arr !== 32'd2271) begin
            bad++;
            $display("FAIL loop_period got en206=%b en205=%b arr410=%0d want 1 0 2271",
                     obs_q[206].en, obs_q[205].en, obs_q[410].arr);
        end
        do_reset();
    endtask

    task automatic test_stop();
        foreach (rom[i]) rom[i] = 8'h00;
        rom[0] = 8'h46;
        do_reset();
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (52) @(posedge clk);
        #1;
        total++;
        if (cnt_en !== 1'b1) begin
            bad++;
            $display("FAIL stop_precondition got en=%b want 1", cnt_en);
        end
        stop = 1'b1;
        @(posedge clk);
        #1 stop = 1'b0;
        for (int i = 0; i < 4; i++) begin
            total++;
            if ({cnt_en, busy, done} !== 3'b000 || counter_arr !== 32'd0 ||
                counter_ccr !== 32'd0 || rom_addr !== '0) begin
                bad++;
                $display("FAIL stop_idle cycle=%0d got en=%b busy=%b done=%b arr=%0d ccr=%0d addr=%0d want all 0",
                         i, cnt_en, busy, done, counter_arr, counter_ccr, rom_addr);
            end
            @(posedge clk);
            #1;
        end
        play(1'b0, 206, -1, "stop_replay");
    endtask

    task automatic test_start_ignored();
        foreach (rom[i]) rom[i] = 8'h00;
        rom[0] = 8'h46;
        do_reset();
        play(1'b0, 208, 40, "start_while_busy");
        @(posedge clk);
        #1 start = 1'b1; stop = 1'b1;
        @(posedge clk);
        #1 start = 1'b0; stop = 1'b0;
        for (int i = 0; i < 3; i++) begin
            total++;
            if (busy !== 1'b0 || rom_addr !== '0 || cnt_en !== 1'b0) begin
                bad++;
                $display("FAIL start_stop_idle cycle=%0d got busy=%b addr=%0d en=%b want 0 0 0",
                         i, busy, rom_addr, cnt_en);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_async_reset();
        foreach (rom[i]) rom[i] = 8'h00;
        rom[0] = 8'h46;
        do_reset();
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (30) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        total++;
        if ({busy, done, cnt_en} !== 3'b000 || rom_addr !== '0 || counter_arr !== 32'd0 ||
            counter_ccr !== 32'd0) begin
            bad++;
            $display("FAIL async_reset got busy=%b done=%b en=%b addr=%0d arr=%0d ccr=%0d want all 0",
                     busy, done, cnt_en, rom_addr, counter_arr, counter_ccr);
        end
        @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1;
        total++;
        if (busy !== 1'b0 || cnt_en !== 1'b0) begin
            bad++;
            $display("FAIL async_reset_after got busy=%b en=%b want 0 0", busy, cnt_en);
        end
    endtask

    task automatic test_wrap();
        foreach (rom[i]) rom[i] = 8'h21;
        do_reset();
        play(1'b0, 18 * 102, -1, "wrap");
        do_reset();
    endtask

    task automatic test_random();
        int len, n, d;
        for (int it = 0; it < 4; it++) begin
            foreach (rom[i]) rom[i] = 8'($urandom);
            len = int'($urandom_range(1, 6));
            n = 0;
            for (int i = 0; i < len; i++) begin
                d = int'($urandom_range(1, 2));
                rom[i] = {3'(d), 5'($urandom_range(0, 31))};
                n += d * int'(BEAT) + 2;
            end
            rom[len] = {3'd0, 5'($urandom_range(0, 31))};
            do_reset();
            play(1'b0, n + 6, -1, "random");
        end
    endtask

    initial begin
        test_reset();
        test_single_note();
        test_note_rest();
        test_loop();
        test_stop();
        test_start_ignored();
        test_async_reset();
        test_wrap();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
